// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================
// mdu_pkg : op encodings, FSM state type, iteration default
// Rev 1.0
// ============================================================
package mdu_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_divstep.sv
`default_nettype none
// ============================================================
// mdu_divstep : one combinational restoring-division step
// Rev 1.0
// ============================================================
module mdu_divstep (
  input  logic [31:0] rem_in,
  input  logic        shift_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        qbit
);

  logic [32:0] w_shifted;
  logic [32:0] w_trial;

  // rem_in < divisor, so the shifted value fits 33 bits and bit 32 of the
  // trial difference is the borrow.
  assign w_shifted = {rem_in, shift_in};
  assign w_trial   = w_shifted - {1'b0, divisor};
  assign qbit      = ~w_trial[32];
  assign rem_out   = qbit ? w_trial[31:0] : w_shifted[31:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================
// mult_div_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO
// Rev 1.0
// ============================================================
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  localparam logic [5:0] c_last = 6'(ITER - 1);

  mdu_state_t  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_neg;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_dz;

  logic        w_signed;
  logic        w_is_div;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_prod;
  logic [31:0] w_rem_next;
  logic        w_qbit;
  logic [63:0] w_div_next;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_abs_a  = (w_signed && A[31]) ? -A : A;
  assign w_abs_b  = (w_signed && B[31]) ? -B : B;

  // Shift-add: accumulate into the upper word, shift the multiplier out the bottom.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};
  assign w_prod     = r_neg ? -w_mul_next : w_mul_next;

  mdu_divstep u_divstep (
    .rem_in   (r_acc[63:32]),
    .shift_in (r_acc[31]),
    .divisor  (r_b),
    .rem_out  (w_rem_next),
    .qbit     (w_qbit)
  );

  assign w_div_next = {w_rem_next, r_acc[30:0], w_qbit};
  assign w_quot     = r_neg   ? -w_div_next[31:0]  : w_div_next[31:0];
  assign w_rem      = r_neg_r ? -w_div_next[63:32] : w_div_next[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_acc   <= 64'd0;
      r_b     <= 32'd0;
      r_neg   <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= {32'd0, w_abs_a};
            r_b     <= w_abs_b;
            r_neg   <= w_signed & (A[31] ^ B[31]);
            r_neg_r <= w_signed & A[31];
            r_cnt   <= 6'd0;
            if (w_is_div && (B == 32'd0)) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
            end else begin
              r_state <= w_is_div ? S_DIV : S_MUL;
            end
          end else begin
            if (mthi) r_hi <= A;
            if (mtlo) r_lo <= A;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_last) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_last) begin
            r_hi    <= w_rem;
            r_lo    <= w_quot;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================
// tb_mult_div_unit : directed scoreboard bench for mult_div_unit
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int ITER = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        dz;

  exp_t        scb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p, uq, ur;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    e.dz  = 1'b0;
    e.lat = ITER + 1;
    e.hi  = m_hi;
    e.lo  = m_lo;
    case (o)
      OP_MULT: begin
        p = 64'(sa * sbv);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.dz  = 1'b1;
          e.lat = 1;
        end else if (o == OP_DIV) begin
          q = sa / sbv; r = sa % sbv;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
          e.lo = uq[31:0]; e.hi = ur[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Issue one op, optionally with a move alongside start and an illegal
  // start/move pulse at cycle 'poke' while busy; then check the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mv, input int poke);
    exp_t e;
    int   lat;
    op = o; A = a; B = b; start = 1'b1; mthi = mv; mtlo = mv;
    scb.push_back(model(o, a, b));
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    A = $urandom; B = $urandom;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == poke) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = ~o;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    e = scb.pop_front();
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".lat"},  64'(lat),  64'(e.lat));
    check({tag, ".hi"},   64'(HI),   64'(e.hi));
    check({tag, ".lo"},   64'(LO),   64'(e.lo));
    check({tag, ".dz"},   64'(dz),   64'(e.dz));
    m_hi = e.hi; m_lo = e.lo;
    tick();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".idle"},       64'(busy), 64'd0);
  endtask

  initial begin
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.dz",   64'(dz),   64'd0);
    check("rst.hilo", {HI, LO},  64'd0);
    rst_n = 1'b1;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("multu_max.hi_lit", 64'(HI), 64'hFFFF_FFFE);
    check("multu_max.lo_lit", 64'(LO), 64'h0000_0001);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    check("mult_neg.lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("div_neg.lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu",     OP_DIVU, 32'd7, 32'd2, 1'b0, 0);
    check("divu.lit", {HI, LO}, {32'd1, 32'd3});

    // HI/LO moves: single and combined
    A = 32'h0000_ABCD; mthi = 1'b1; mtlo = 1'b1; tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mv_both", {HI, LO}, {32'h0000_ABCD, 32'h0000_ABCD});
    A = 32'h0000_1234; mthi = 1'b1; tick(); mthi = 1'b0;
    check("mthi", {HI, LO}, {32'h0000_1234, 32'h0000_ABCD});
    A = 32'h0000_5678; mtlo = 1'b1; tick(); mtlo = 1'b0;
    check("mtlo", {HI, LO}, {32'h0000_1234, 32'h0000_5678});
    m_hi = 32'h0000_1234; m_lo = 32'h0000_5678;

    run_op("div_zero", OP_DIV, 32'h0000_9999, 32'd0, 1'b1, 0);
    check("div_zero.lit", {HI, LO}, {32'h0000_1234, 32'h0000_5678});
    run_op("divu_zero", OP_DIVU, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("div_ovf.lit", {HI, LO}, {32'd0, 32'h8000_0000});
    run_op("mult_poke", OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 5);
    run_op("divu_poke", OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0, 20);
    run_op("mult_mv",   OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'hFFFF_FFFF : ($urandom >> $urandom_range(0, 31)) | 32'd1;
      run_op("rand", ro, ra, rb, 1'b0, 0);
    end

    // Reset in the middle of a DIVU, asserted between clock edges
    op = OP_DIVU; A = 32'd1000; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_rst.busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.hilo", {HI, LO},  64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("rst_mid.no_write", {HI, LO}, 64'd0);
    check("rst_mid.idle",     64'(busy), 64'd0);
    run_op("after_rst", OP_DIVU, 32'd1000, 32'd7, 1'b0, 0);
    run_op("after_rst_b2b", OP_MULT, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
